// File: rtl/systolic_pkg.sv
// Shared FSM encoding and default sizing for the systolic array feeder.
package systolic_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_ROWS       = 2;
  localparam int unsigned DEF_COLS       = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_ACT    = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Width of a counter that must hold values 0..n (never narrower than 1 bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth delay line for one array row: data, element-valid and end marker.
// Data stages only advance when a real element moves into them, so bubbles
// leave the previously presented value on the output.
module skew_delay_line #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  en_i,
  input  logic                  end_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  en_o,
  output logic                  end_o
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]                 en_q, en_d;
  logic [DEPTH-1:0]                 end_q, end_d;

  // Next-stage values: enables and end markers always shift, data only with an element.
  always_comb begin
    data_d = data_q;
    en_d   = '0;
    end_d  = '0;
    en_d[0]  = en_i;
    end_d[0] = end_i;
    if (en_i) begin
      data_d[0] = data_i;
    end
    for (int k = 1; k < int'(DEPTH); k++) begin
      en_d[k]  = en_q[k-1];
      end_d[k] = end_q[k-1];
      if (en_q[k-1]) begin
        data_d[k] = data_q[k-1];
      end
    end
  end

  // Stage registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      en_q   <= '0;
      end_q  <= '0;
    end else begin
      data_q <= data_d;
      en_q   <= en_d;
      end_q  <= end_d;
    end
  end

  assign data_o = data_q[DEPTH-1];
  assign en_o   = en_q[DEPTH-1];
  assign end_o  = end_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Feeds weights and diagonally skewed activations into a ROWS x COLS systolic
// array: loads ROWS weight rows, streams activation columns, then flushes
// until the last element has left the deepest row.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ROWS       = DEF_ROWS,
  parameter int unsigned COLS       = DEF_COLS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start_i,
  input  logic [COLS-1:0][DATA_WIDTH-1:0] w_vec_i,
  input  logic                            w_valid_i,
  output logic                            w_ready_o,
  input  logic [ROWS-1:0][DATA_WIDTH-1:0] a_vec_i,
  input  logic                            a_valid_i,
  input  logic                            a_last_i,
  output logic                            a_ready_o,
  output logic [COLS-1:0][DATA_WIDTH-1:0] weight_o,
  output logic [COLS-1:0]                 WEIGHT_ENABLE_o,
  output logic [ROWS-1:0][DATA_WIDTH-1:0] activation_o,
  output logic [ROWS-1:0]                 ACTIVATION_ENABLE_o,
  output logic [ROWS-1:0]                 END_SIGNAL_o,
  output logic                            STOP_WEIGHT_o,
  output logic                            CLEAR_ALL_o,
  output logic                            busy_o,
  output logic                            done_o
);

  localparam int unsigned CNT_W = cnt_width(ROWS);

  state_e                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [COLS-1:0][DATA_WIDTH-1:0] weight_q, weight_d;
  logic [COLS-1:0]                 wen_q, wen_d;
  logic                            w_ready_q, w_ready_d;
  logic                            a_ready_q, a_ready_d;
  logic                            stop_q, stop_d;
  logic                            clear_q, clear_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;

  logic w_hs;
  logic a_hs;

  assign w_hs = w_valid_i & w_ready_q;
  assign a_hs = a_valid_i & a_ready_q;

  // Next state and next registered outputs; cnt_q counts weight rows in LOAD_W
  // and drain cycles in FLUSH.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    weight_d = weight_q;
    wen_d    = '0;
    clear_d  = 1'b0;

    if (w_hs) begin
      weight_d = w_vec_i;
      wen_d    = '1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_LOAD_W;
          cnt_d   = '0;
          clear_d = 1'b1;
        end
      end
      ST_LOAD_W: begin
        if (w_hs) begin
          if (cnt_q == CNT_W'(ROWS - 1)) begin
            state_d = ST_ACT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_ACT: begin
        if (a_hs && a_last_i) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == CNT_W'(ROWS - 1)) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    w_ready_d = (state_d == ST_LOAD_W);
    a_ready_d = (state_d == ST_ACT);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    stop_d    = (state_d == ST_ACT) || (state_d == ST_FLUSH) || (state_d == ST_DONE);
  end

  // State and registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      weight_q  <= '0;
      wen_q     <= '0;
      w_ready_q <= 1'b0;
      a_ready_q <= 1'b0;
      stop_q    <= 1'b0;
      clear_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      weight_q  <= weight_d;
      wen_q     <= wen_d;
      w_ready_q <= w_ready_d;
      a_ready_q <= a_ready_d;
      stop_q    <= stop_d;
      clear_q   <= clear_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // One delay line per row; row r sits r cycles behind row 0.
  for (genvar r = 0; r < int'(ROWS); r++) begin : g_row
    skew_delay_line #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (r + 1)
    ) u_skew (
      .clk    (clk),
      .rst_n  (rst_n),
      .data_i (a_vec_i[r]),
      .en_i   (a_hs),
      .end_i  (a_hs & a_last_i),
      .data_o (activation_o[r]),
      .en_o   (ACTIVATION_ENABLE_o[r]),
      .end_o  (END_SIGNAL_o[r])
    );
  end

  assign weight_o        = weight_q;
  assign WEIGHT_ENABLE_o = wen_q;
  assign w_ready_o       = w_ready_q;
  assign a_ready_o       = a_ready_q;
  assign STOP_WEIGHT_o   = stop_q;
  assign CLEAR_ALL_o     = clear_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized self-checking bench for systolic_feeder against a job-level model.
module tb_systolic_feeder;

  localparam int unsigned DW = 16;
  localparam int unsigned R  = 2;
  localparam int unsigned C  = 2;
  localparam int SB = 64;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start_i = 1'b0;
  logic [C-1:0][DW-1:0]    w_vec_i = '0;
  logic                    w_valid_i = 1'b0;
  logic                    w_ready_o;
  logic [R-1:0][DW-1:0]    a_vec_i = '0;
  logic                    a_valid_i = 1'b0;
  logic                    a_last_i = 1'b0;
  logic                    a_ready_o;
  logic [C-1:0][DW-1:0]    weight_o;
  logic [C-1:0]            weight_en;
  logic [R-1:0][DW-1:0]    activation_o;
  logic [R-1:0]            act_en;
  logic [R-1:0]            end_sig;
  logic                    stop_w;
  logic                    clear_all;
  logic                    busy_o;
  logic                    done_o;

  always #5 clk = ~clk;

  systolic_feeder #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start_i             (start_i),
    .w_vec_i             (w_vec_i),
    .w_valid_i           (w_valid_i),
    .w_ready_o           (w_ready_o),
    .a_vec_i             (a_vec_i),
    .a_valid_i           (a_valid_i),
    .a_last_i            (a_last_i),
    .a_ready_o           (a_ready_o),
    .weight_o            (weight_o),
    .WEIGHT_ENABLE_o     (weight_en),
    .activation_o        (activation_o),
    .ACTIVATION_ENABLE_o (act_en),
    .END_SIGNAL_o        (end_sig),
    .STOP_WEIGHT_o       (stop_w),
    .CLEAR_ALL_o         (clear_all),
    .busy_o              (busy_o),
    .done_o              (done_o)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
  endtask

  // Job-level model: where the current job stands, plus a per-cycle schedule
  // of the skewed activation elements each row must present.
  bit                   m_in_job, m_loading, m_streaming, m_clear, m_wen_nxt;
  int                   m_wcnt, m_done_cyc;
  logic [C-1:0][DW-1:0] m_weight, m_weight_nxt;
  bit                   s_en  [SB][R];
  bit                   s_end [SB][R];
  logic [DW-1:0]        s_dat [SB][R];
  logic [DW-1:0]        m_row [R];

  task automatic model_reset();
    m_in_job = 0; m_loading = 0; m_streaming = 0; m_clear = 0; m_wen_nxt = 0;
    m_wcnt = 0; m_done_cyc = -1;
    m_weight = '0; m_weight_nxt = '0;
    for (int s = 0; s < SB; s++)
      for (int r = 0; r < int'(R); r++) begin
        s_en[s][r] = 0; s_end[s][r] = 0; s_dat[s][r] = '0;
      end
    for (int r = 0; r < int'(R); r++) m_row[r] = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  64'(busy_o), 64'(0));
    check({tag, "_wrdy"},  64'(w_ready_o), 64'(0));
    check({tag, "_ardy"},  64'(a_ready_o), 64'(0));
    check({tag, "_stop"},  64'(stop_w), 64'(0));
    check({tag, "_clear"}, 64'(clear_all), 64'(0));
    check({tag, "_done"},  64'(done_o), 64'(0));
    check({tag, "_wen"},   64'(weight_en), 64'(0));
    check({tag, "_wdat"},  64'(weight_o), 64'(0));
    check({tag, "_aen"},   64'(act_en), 64'(0));
    check({tag, "_end"},   64'(end_sig), 64'(0));
    check({tag, "_adat"},  64'(activation_o), 64'(0));
  endtask

  task automatic check_outputs();
    int slot;
    slot = cyc % SB;
    check("busy",  64'(busy_o),    64'(m_in_job));
    check("wrdy",  64'(w_ready_o), 64'(m_loading));
    check("ardy",  64'(a_ready_o), 64'(m_streaming));
    check("stop",  64'(stop_w),    64'(m_in_job && !m_loading));
    check("clear", 64'(clear_all), 64'(m_clear));
    check("done",  64'(done_o),    64'(m_in_job && cyc == m_done_cyc));
    if (m_wen_nxt) m_weight = m_weight_nxt;
    check("wen",   64'(weight_en), m_wen_nxt ? 64'((1 << C) - 1) : 64'(0));
    check("wdat",  64'(weight_o),  64'(m_weight));
    for (int r = 0; r < int'(R); r++) begin
      if (s_en[slot][r]) m_row[r] = s_dat[slot][r];
      check($sformatf("aen%0d", r),  64'(act_en[r]),       64'(s_en[slot][r]));
      check($sformatf("end%0d", r),  64'(end_sig[r]),      64'(s_end[slot][r]));
      check($sformatf("adat%0d", r), 64'(activation_o[r]), 64'(m_row[r]));
      s_en[slot][r] = 0; s_end[slot][r] = 0;
    end
  endtask

  // Apply the rules to the inputs driven in the current cycle, advance one clock, compare.
  task automatic tick();
    bit nx_in_job, nx_loading, nx_stream;
    int nx_wcnt, slot;
    nx_in_job = m_in_job; nx_loading = m_loading; nx_stream = m_streaming; nx_wcnt = m_wcnt;
    m_wen_nxt = 0;
    m_clear = 0;
    if (!m_in_job && start_i) begin
      nx_in_job = 1; nx_loading = 1; nx_wcnt = 0; m_clear = 1;
    end
    if (m_in_job && cyc == m_done_cyc) nx_in_job = 0;
    if (m_loading && w_valid_i) begin
      m_wen_nxt = 1; m_weight_nxt = w_vec_i;
      nx_wcnt++;
      if (nx_wcnt == int'(R)) begin nx_loading = 0; nx_stream = 1; end
    end
    if (m_streaming && a_valid_i) begin
      for (int r = 0; r < int'(R); r++) begin
        slot = (cyc + 1 + r) % SB;
        s_en[slot][r] = 1; s_end[slot][r] = a_last_i; s_dat[slot][r] = a_vec_i[r];
      end
      if (a_last_i) begin nx_stream = 0; m_done_cyc = cyc + int'(R) + 1; end
    end
    m_in_job = nx_in_job; m_loading = nx_loading; m_streaming = nx_stream; m_wcnt = nx_wcnt;
    @(posedge clk); #1;
    cyc++;
    check_outputs();
  endtask

  task automatic drain(input bit start_noise);
    int guard;
    guard = 0;
    a_valid_i = 0; w_valid_i = 0;
    while (m_in_job && guard < 50) begin
      start_i = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      guard++;
    end
    check("drain_timeout", 64'(m_in_job), 64'(0));
    start_i = 0;
  endtask

  task automatic run_job(input int n_act, input int wprob, input int aprob, input bit noise);
    int guard, k;
    start_i = 1;
    tick();
    guard = 0;
    while (m_loading && guard < 200) begin
      w_valid_i = ($urandom_range(0, 99) < wprob);
      w_vec_i   = C*DW'($urandom());
      a_valid_i = 1'($urandom_range(0, 1));
      start_i   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      guard++;
    end
    check("wload_timeout", 64'(m_loading), 64'(0));
    w_valid_i = 0;
    k = 0; guard = 0;
    while (k < n_act && guard < 400) begin
      a_valid_i = ($urandom_range(0, 99) < aprob);
      a_vec_i   = R*DW'($urandom());
      a_last_i  = a_valid_i ? (k == n_act - 1) : 1'($urandom_range(0, 1));
      w_valid_i = 1'($urandom_range(0, 1));
      start_i   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (a_valid_i && m_streaming) k++;
      tick();
      guard++;
    end
    check("act_timeout", 64'(k), 64'(n_act));
    a_last_i = 0;
    drain(noise);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    model_reset();
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1;

    // Directed job: weights {1,2},{3,4}; activations {5,6}, bubble, {7,8} last.
    start_i = 1; tick(); start_i = 0;
    check("dir_clear", 64'(clear_all), 64'(1));
    w_valid_i = 1; w_vec_i[0] = 16'd1; w_vec_i[1] = 16'd2; tick();
    w_vec_i[0] = 16'd3; w_vec_i[1] = 16'd4; tick();
    w_valid_i = 0;
    check("dir_stop", 64'(stop_w), 64'(1));
    a_valid_i = 1; a_vec_i[0] = 16'd5; a_vec_i[1] = 16'd6; a_last_i = 0; tick();
    check("dir_row0_5", 64'(activation_o[0]), 64'(5));
    a_valid_i = 0; tick();
    check("dir_row1_6", 64'(activation_o[1]), 64'(6));
    a_valid_i = 1; a_vec_i[0] = 16'd7; a_vec_i[1] = 16'd8; a_last_i = 1; tick();
    a_valid_i = 0; a_last_i = 0;
    drain(0);
    tick(); tick();

    // Start held high through the whole job, including DONE.
    start_i = 1; tick();
    w_valid_i = 1; w_vec_i = C*DW'($urandom()); tick(); tick();
    w_valid_i = 0;
    a_valid_i = 1; a_last_i = 1; a_vec_i = R*DW'($urandom()); tick();
    a_valid_i = 0; a_last_i = 0;
    while (m_in_job && cyc < 100000) tick();
    start_i = 0;
    tick(); tick();

    // Reset while row 1 still holds a pending element.
    start_i = 1; tick(); start_i = 0;
    w_valid_i = 1; tick(); tick(); w_valid_i = 0;
    a_valid_i = 1; a_last_i = 0; a_vec_i = R*DW'($urandom()); tick();
    a_last_i = 1; a_vec_i = R*DW'($urandom()); tick();
    a_valid_i = 0; a_last_i = 0;
    rst_n = 0; #1;
    check_all_zero("midrst");
    model_reset();
    #20;
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 5; i++) tick();
    run_job(3, 100, 100, 0);

    // Randomized jobs.
    for (int j = 0; j < 20; j++)
      run_job(int'($urandom_range(1, 8)), int'($urandom_range(30, 100)),
              int'($urandom_range(30, 100)), 1'(j % 2));
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, meaning operand width.
REQ-002 The block SHALL have parameter ROWS, default 2, meaning array rows fed.
REQ-003 The block SHALL have parameter COLS, default 2, meaning array columns fed.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset, as the ports below.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start_i  in  1  begin one job; sampled only in IDLE.
REQ-008 w_vec_i  in  COLS x DATA_WIDTH  one weight row; w_valid_i in 1; w_ready_o out 1.
REQ-009 a_vec_i  in  ROWS x DATA_WIDTH  one activation column; a_valid_i in 1; a_last_i in 1; a_ready_o out 1.
REQ-010 weight_o  out  COLS x DATA_WIDTH, WEIGHT_ENABLE_o out COLS x 1  array weight inputs.
REQ-011 activation_o  out  ROWS x DATA_WIDTH, ACTIVATION_ENABLE_o out ROWS x 1, END_SIGNAL_o out ROWS x 1  array activation inputs.
REQ-012 STOP_WEIGHT_o  out  1; CLEAR_ALL_o  out  1  array global controls.
REQ-013 busy_o  out  1  state != IDLE; done_o  out  1  one-cycle job-complete pulse.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD_W, ACT, FLUSH, DONE.
REQ-015 IDLE->LOAD_W when start_i=1; CLEAR_ALL_o SHALL be 1 for exactly that transition cycle, else 0.
REQ-016 In LOAD_W w_ready_o SHALL be 1; a weight handshake (w_valid_i & w_ready_o) SHALL register w_vec_i to weight_o with all WEIGHT_ENABLE_o=1 the next cycle; no handshake -> WEIGHT_ENABLE_o=0, weight_o holds.
REQ-017 After exactly ROWS weight handshakes, LOAD_W->ACT; STOP_WEIGHT_o SHALL be 1 from the cycle after the final weight handshake until IDLE is re-entered.
REQ-018 In ACT a_ready_o SHALL be 1; elsewhere a_ready_o and w_ready_o SHALL be 0.
REQ-019 Activation handshake at cycle t: row r SHALL present a_vec_i[r] with ACTIVATION_ENABLE_o[r]=1 at cycle t+1+r (diagonal skew).
REQ-020 Cycles without a handshake in ACT SHALL propagate bubbles: enable 0 at the same skewed position; data value don't-care but held.
REQ-021 END_SIGNAL_o[r] SHALL be 1 alongside the skewed element of the handshake carrying a_last_i=1, else 0.
REQ-022 Handshake with a_last_i=1 at cycle t: ACT->FLUSH at t+1; FLUSH->DONE once row ROWS-1 has emitted the last element (cycle t+ROWS); done_o=1 in DONE (cycle t+ROWS+1); DONE->IDLE next cycle.
REQ-023 start_i while not IDLE SHALL be ignored; start_i in DONE SHALL be ignored.
REQ-024 ROWS=1 SHALL work (no skew stage beyond the output register).

Reset
REQ-025 On rst_n=0, asynchronously: state=IDLE; all enables, END_SIGNAL_o, STOP_WEIGHT_o, CLEAR_ALL_o, done_o, busy_o, ready outputs=0; weight_o, activation_o and all skew registers=0.
REQ-026 Reset mid-job SHALL discard all in-flight skewed data; no enable or END pulse after reset release without a new job.

Structure
REQ-027 A shared package systolic_pkg SHALL hold the FSM state enum and the default DATA_WIDTH/ROWS/COLS constants.
REQ-028 One sub-module skew_delay_line (parameter DEPTH; data, enable, end through DEPTH register stages, async-reset) SHALL be instantiated per row with DEPTH=r+1.

Verification (ROWS=COLS=2)
REQ-029 start_i pulse -> CLEAR_ALL_o=1 one cycle, busy_o=1, w_ready_o=1 next cycle.
REQ-030 Weights {1,2},{3,4} back-to-back -> weight_o {1,2} then {3,4} with WEIGHT_ENABLE_o=11, STOP_WEIGHT_o=1 from the cycle after the second handshake, a_ready_o=1.
REQ-031 Activations {5,6} at t, {7,8} last at t+1 -> row0: 5@t+1, 7@t+2 END; row1: 6@t+2, 8@t+3 END; done_o=1 at t+3+1=t+4 for one cycle... as per REQ-022 (t'=t+1: done at t+4), then IDLE.
REQ-032 a_valid_i gap one cycle between {5,6} and {7,8} -> bubble (enable 0) at row0 t+2, row1 t+3; data aligned thereafter.
REQ-033 rst_n=0 asserted while row1 still holds a pending element -> all outputs 0 immediately; no enable after release; start_i accepted again.
REQ-034 start_i held high during ACT and DONE -> no CLEAR_ALL_o, no restart until IDLE.
